// File: rtl/riscv_pipeline_complete_pkg.sv
// Shared ISA constants, control/pipeline-register types and small helpers for the 5-stage core.
package riscv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BYTE    = 3'b000;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SRL = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic    regwrite;
        logic    memread;
        logic    memwrite;
        logic    alusrc;
        alu_op_e aluop;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } idex_t;

    typedef struct packed {
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  rd;
    } exmem_t;

    typedef struct packed {
        logic        regwrite;
        logic        memread;
        logic [31:0] alu;
        logic [31:0] load;
        logic [4:0]  rd;
    } memwb_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    function automatic logic [31:0] sext8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

endpackage

// File: rtl/riscv_pipeline_complete_dmem.sv
// Byte-addressed data memory: asynchronous read, write on the rising edge, never cleared by reset.
module riscv_dmem #(
    parameter int DMEM_BYTES = 128,
    parameter int AW         = $clog2(DMEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [0:DMEM_BYTES-1];

    // Byte store.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/riscv_pipeline_complete_regfile.sv
// 31 x 32-bit register file; x0 reads as zero, reads bypass a same-cycle write.
module riscv_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] register1,  register2,  register3,  register4,  register5,  register6,  register7,  register8;
    logic [31:0] register9,  register10, register11, register12, register13, register14, register15, register16;
    logic [31:0] register17, register18, register19, register20, register21, register22, register23, register24;
    logic [31:0] register25, register26, register27, register28, register29, register30, register31;

    logic [31:1][31:0] regs_q;
    logic [31:1][31:0] regs_d;

    assign regs_q = {register31, register30, register29, register28, register27, register26, register25, register24,
                     register23, register22, register21, register20, register19, register18, register17, register16,
                     register15, register14, register13, register12, register11, register10, register9,  register8,
                     register7,  register6,  register5,  register4,  register3,  register2,  register1};

    function automatic logic [31:0] read_port(input logic [4:0] ra);
        if (ra == 5'd0) begin
            return 32'd0;
        end else if (we && (wa == ra)) begin
            return wd;
        end else begin
            return regs_q[ra];
        end
    endfunction

    // Next register contents: only a non-zero destination is written.
    always_comb begin
        regs_d = regs_q;
        if (we && (wa != 5'd0)) begin
            regs_d[wa] = wd;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {register31, register30, register29, register28, register27, register26, register25, register24,
             register23, register22, register21, register20, register19, register18, register17, register16,
             register15, register14, register13, register12, register11, register10, register9,  register8,
             register7,  register6,  register5,  register4,  register3,  register2,  register1} <= '0;
        end else begin
            {register31, register30, register29, register28, register27, register26, register25, register24,
             register23, register22, register21, register20, register19, register18, register17, register16,
             register15, register14, register13, register12, register11, register10, register9,  register8,
             register7,  register6,  register5,  register4,  register3,  register2,  register1} <= regs_d;
        end
    end

    assign rd1 = read_port(ra1);
    assign rd2 = read_port(ra2);

endmodule

// File: rtl/riscv_pipeline_complete.sv
// 5-stage RV32I-subset core with ROM, forwarding and load-use stall.
// Define INTERNAL_CLK_EN to drop the clk port and generate a 10 ns clock internally.
module riscv_pipeline_complete
    import riscv_pkg::*;
#(
    parameter int IMEM_WORDS = 32,
    parameter int DMEM_BYTES = 128
) (
`ifndef INTERNAL_CLK_EN
    input  logic clk,
`endif
    input  logic reset
);
    localparam int DAW = $clog2(DMEM_BYTES);

`ifdef INTERNAL_CLK_EN
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;
`else
`endif

    logic [31:0] pc_q, pc_d, ifid_q, ifid_d;
    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;

    logic [31:0] pc_current, instruction_if, instruction_id;
    logic [4:0]  rd_ex, rd_mem, rd_wb;
    logic [1:0]  ForwardA, ForwardB;
    logic        ControlMux;

    logic [4:0]  id_rs1_s, id_rs2_s;
    logic [31:0] id_rd1_s, id_rd2_s, wb_data_s;
    logic [31:0] fwd_a_s, fwd_b_s, alu_b_s, alu_s;
    logic [7:0]  dmem_rdata_s;

    function automatic logic [31:0] rom_word(input logic [29:0] idx);
        case (idx)
            30'd0:   return 32'h00700093;
            30'd1:   return 32'h00100023;
            30'd2:   return 32'h00000103;
            30'd3:   return 32'h402081B3;
            30'd4:   return 32'h0020F233;
            30'd5:   return 32'h0011E293;
            30'd6:   return 32'h0032D333;
            default: return NOP_INSTR;
        endcase
    endfunction

    // Unsupported encodings decode to all-zero controls and behave as NOP.
    function automatic ctrl_t decode(input logic [31:0] ins);
        ctrl_t c;
        c = '0;
        case (ins[6:0])
            OP_R: begin
                c.regwrite = 1'b1;
                if (ins[31:25] == F7_BASE && ins[14:12] == F3_ADD_SUB)      c.aluop = ALU_ADD;
                else if (ins[31:25] == F7_ALT && ins[14:12] == F3_ADD_SUB)  c.aluop = ALU_SUB;
                else if (ins[31:25] == F7_BASE && ins[14:12] == F3_AND)     c.aluop = ALU_AND;
                else if (ins[31:25] == F7_BASE && ins[14:12] == F3_OR)      c.aluop = ALU_OR;
                else if (ins[31:25] == F7_BASE && ins[14:12] == F3_SRL)     c.aluop = ALU_SRL;
                else                                                        c.regwrite = 1'b0;
            end
            OP_I: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                case (ins[14:12])
                    F3_ADD_SUB: c.aluop = ALU_ADD;
                    F3_AND:     c.aluop = ALU_AND;
                    F3_OR:      c.aluop = ALU_OR;
                    default:    c = '0;
                endcase
            end
            OP_LOAD: begin
                if (ins[14:12] == F3_BYTE) begin
                    c.regwrite = 1'b1;
                    c.memread  = 1'b1;
                    c.alusrc   = 1'b1;
                end else begin
                    c = '0;
                end
            end
            OP_STORE: begin
                if (ins[14:12] == F3_BYTE) begin
                    c.memwrite = 1'b1;
                    c.alusrc   = 1'b1;
                end else begin
                    c = '0;
                end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (exmem_q.regwrite && exmem_q.rd != 5'd0 && exmem_q.rd == rs) begin
            return FWD_MEM;
        end else if (memwb_q.regwrite && memwb_q.rd != 5'd0 && memwb_q.rd == rs) begin
            return FWD_WB;
        end else begin
            return FWD_REG;
        end
    endfunction

    assign pc_current     = pc_q;
    assign instruction_if = (pc_q[31:2] < 30'(IMEM_WORDS)) ? rom_word(pc_q[31:2]) : NOP_INSTR;
    assign instruction_id = ifid_q;
    assign rd_ex          = idex_q.rd;
    assign rd_mem         = exmem_q.rd;
    assign rd_wb          = memwb_q.rd;
    assign id_rs1_s       = ifid_q[19:15];
    assign id_rs2_s       = ifid_q[24:20];
    assign wb_data_s      = memwb_q.memread ? memwb_q.load : memwb_q.alu;

    riscv_regfile reg_file (
        .clk   (clk),
        .reset (reset),
        .we    (memwb_q.regwrite),
        .wa    (memwb_q.rd),
        .wd    (wb_data_s),
        .ra1   (id_rs1_s),
        .ra2   (id_rs2_s),
        .rd1   (id_rd1_s),
        .rd2   (id_rd2_s)
    );

    riscv_dmem #(.DMEM_BYTES(DMEM_BYTES)) data_mem (
        .clk   (clk),
        .we    (exmem_q.memwrite),
        .addr  (exmem_q.alu[DAW-1:0]),
        .wdata (exmem_q.store[7:0]),
        .rdata (dmem_rdata_s)
    );

    // Hazard detection, operand forwarding, ALU and next-state of every pipeline register.
    always_comb begin
        ControlMux = idex_q.ctrl.memread && (idex_q.rd != 5'd0) &&
                     ((idex_q.rd == id_rs1_s) || (idex_q.rd == id_rs2_s));

        pc_d   = ControlMux ? pc_q : (pc_q + 32'd4);
        ifid_d = ControlMux ? ifid_q : instruction_if;

        idex_d = '0;
        if (!ControlMux) begin
            idex_d.ctrl    = decode(ifid_q);
            idex_d.rs1_val = id_rd1_s;
            idex_d.rs2_val = id_rd2_s;
            idex_d.imm     = (ifid_q[6:0] == OP_STORE) ? sext12({ifid_q[31:25], ifid_q[11:7]})
                                                       : sext12(ifid_q[31:20]);
            idex_d.rs1     = id_rs1_s;
            idex_d.rs2     = id_rs2_s;
            idex_d.rd      = ifid_q[11:7];
        end else begin
            idex_d = '0;
        end

        ForwardA = fwd_sel(idex_q.rs1);
        ForwardB = fwd_sel(idex_q.rs2);
        case (ForwardA)
            FWD_MEM: fwd_a_s = exmem_q.alu;
            FWD_WB:  fwd_a_s = wb_data_s;
            default: fwd_a_s = idex_q.rs1_val;
        endcase
        case (ForwardB)
            FWD_MEM: fwd_b_s = exmem_q.alu;
            FWD_WB:  fwd_b_s = wb_data_s;
            default: fwd_b_s = idex_q.rs2_val;
        endcase

        alu_b_s = idex_q.ctrl.alusrc ? idex_q.imm : fwd_b_s;
        case (idex_q.ctrl.aluop)
            ALU_ADD: alu_s = fwd_a_s + alu_b_s;
            ALU_SUB: alu_s = fwd_a_s - alu_b_s;
            ALU_AND: alu_s = fwd_a_s & alu_b_s;
            ALU_OR:  alu_s = fwd_a_s | alu_b_s;
            ALU_SRL: alu_s = fwd_a_s >> alu_b_s[4:0];
            default: alu_s = fwd_a_s + alu_b_s;
        endcase

        exmem_d.regwrite = idex_q.ctrl.regwrite;
        exmem_d.memread  = idex_q.ctrl.memread;
        exmem_d.memwrite = idex_q.ctrl.memwrite;
        exmem_d.alu      = alu_s;
        exmem_d.store    = fwd_b_s;
        exmem_d.rd       = idex_q.rd;

        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.memread  = exmem_q.memread;
        memwb_d.alu      = exmem_q.alu;
        memwb_d.load     = sext8(dmem_rdata_s);
        memwb_d.rd       = exmem_q.rd;
    end

    // Pipeline registers; reset loads NOPs everywhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= 32'd0;
            ifid_q  <= NOP_INSTR;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

endmodule

// File: tb/tb_riscv_pipeline_complete.sv
// Scoreboard bench for riscv_pipeline_complete running the default ROM program.
module tb_riscv_pipeline_complete;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    riscv_pipeline_complete dut (
        .clk   (clk),
        .reset (reset)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, got, e.val);
        end
    endtask

    function automatic logic [31:0] get_reg(input int i);
        case (i)
            1:       return dut.reg_file.register1;
            2:       return dut.reg_file.register2;
            3:       return dut.reg_file.register3;
            4:       return dut.reg_file.register4;
            5:       return dut.reg_file.register5;
            6:       return dut.reg_file.register6;
            default: return 32'd0;
        endcase
    endfunction

    // Expected architectural results of the default program, x1..x6.
    function automatic logic [31:0] model_reg(input int i);
        case (i)
            1:       return 32'd7;
            2:       return 32'd7;
            3:       return 32'd0;
            4:       return 32'd7;
            5:       return 32'd1;
            6:       return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_pc(input int c);
        return (c <= 4) ? 32'(4 * c) : 32'(4 * (c - 1));
    endfunction

    // Called at the negedge where reset drops; cycle 0 is the window before the first rising edge.
    task automatic run_program(input string pfx);
        for (int c = 0; c < 12; c++) begin
            push_exp($sformatf("%s_pc_c%0d", pfx, c), model_pc(c));
            push_exp($sformatf("%s_stall_c%0d", pfx, c), (c == 4) ? 32'd1 : 32'd0);
            if (c == 3) push_exp($sformatf("%s_fwdB_sb", pfx), 32'd2);
            if (c == 5) push_exp($sformatf("%s_id_sub_held", pfx), 32'h402081B3);
            if (c == 6) push_exp($sformatf("%s_fwdB_sub", pfx), 32'd1);
            if (c == 8) push_exp($sformatf("%s_fwdA_ori", pfx), 32'd1);
            if (c == 9) begin
                push_exp($sformatf("%s_fwdA_srl", pfx), 32'd2);
                push_exp($sformatf("%s_fwdB_srl", pfx), 32'd0);
            end
        end
        for (int c = 0; c < 20; c++) begin
            #1;
            if (c < 12) begin
                pop_check(dut.pc_current);
                pop_check(32'(dut.ControlMux));
                if (c == 3) pop_check(32'(dut.ForwardB));
                if (c == 5) pop_check(dut.instruction_id);
                if (c == 6) pop_check(32'(dut.ForwardB));
                if (c == 8) pop_check(32'(dut.ForwardA));
                if (c == 9) begin
                    pop_check(32'(dut.ForwardA));
                    pop_check(32'(dut.ForwardB));
                end
            end
            @(negedge clk);
        end
        #1;
        for (int i = 1; i <= 6; i++) push_exp($sformatf("%s_x%0d", pfx, i), model_reg(i));
        push_exp($sformatf("%s_mem0", pfx), 32'h07);
        for (int i = 1; i <= 6; i++) pop_check(get_reg(i));
        pop_check(32'(dut.data_mem.mem[0]));
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_program("run1");

        // Past the program end only NOPs are fetched and state stays put.
        repeat (20) @(negedge clk);
        #1;
        check_val("nop_fetch", dut.instruction_if, 32'h00000013);
        for (int i = 1; i <= 6; i++) check_val($sformatf("idle_x%0d", i), get_reg(i), model_reg(i));
        check_val("idle_mem0", 32'(dut.data_mem.mem[0]), 32'h07);

        // Restart the program, then hit reset at cycle 8.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        push_exp("midreset_pc", 32'd0);
        for (int i = 1; i <= 6; i++) push_exp($sformatf("midreset_x%0d", i), 32'd0);
        pop_check(dut.pc_current);
        for (int i = 1; i <= 6; i++) pop_check(get_reg(i));
        @(negedge clk);
        reset = 1'b0;
        run_program("run2");

        check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
